// File: rtl/ldst_control_unit.sv
// ldst_control_unit: hardwired Moore control-step sequencer for instruction
// fetch and the ld / ldi / st memory instructions. One control step per
// Clock cycle; every strobe is decoded from the current step and the opcode
// captured at entry to T3.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_RESET | idle after reset, all strobes low, Run low
//   S_T0    | PC -> MAR, PC incremented
//   S_T1    | memory read into MDR
//   S_T2    | MDR -> IR
//   S_T3    | base register -> Y (opcode captured on entry)
//   S_T4    | Y + C -> Z
//   S_T5    | Z -> MAR (ld/st) or Z -> Ra (ldi, last step)
//   S_T6    | read into MDR (ld) or Ra -> MDR (st)
//   S_T7    | MDR -> Ra (ld) or memory write (st), last step
//   S_HALT  | stopped until Reset, all strobes low, Run low
module ldst_control_unit #(
  parameter logic [4:0] OP_LD   = 5'b00000,
  parameter logic [4:0] OP_LDI  = 5'b00001,
  parameter logic [4:0] OP_ST   = 5'b00010,
  parameter logic [4:0] OP_HALT = 5'b11011,
  parameter logic [4:0] ALU_ADD = 5'b00011
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Cout,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  operation,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     state, state_next;
  logic [4:0] opc;

  // Only the opcode field steers the sequence; the operand fields go to the datapath.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  // State register; opcode is captured on the T2 -> T3 edge so later IR changes are ignored.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_RESET;
      opc   <= 5'b00000;
    end else begin
      state <= state_next;
      if (state == S_T2) opc <= IR[31:27];
    end
  end

  // Next-step selection; Stop only matters on the final step of an instruction.
  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3: begin
        if (opc == OP_HALT)
          state_next = S_HALT;
        else if (opc == OP_LD || opc == OP_LDI || opc == OP_ST)
          state_next = S_T4;
        else
          state_next = S_T0;
      end
      S_T4:    state_next = S_T5;
      S_T5: begin
        if (opc == OP_LDI) state_next = Stop ? S_HALT : S_T0;
        else               state_next = S_T6;
      end
      S_T6:    state_next = S_T7;
      S_T7:    state_next = Stop ? S_HALT : S_T0;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end

  // Moore output decode from the current step and captured opcode.
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; MARin = 1'b0; Zin = 1'b0;
    PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; IncPC = 1'b0;
    Read = 1'b0; Write = 1'b0; Cout = 1'b0; GRA = 1'b0; GRB = 1'b0;
    GRC = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    operation = 5'b00000;
    Run = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      S_T4: begin Cout = 1'b1; operation = ALU_ADD; Zin = 1'b1; end
      S_T5: begin
        Zlowout = 1'b1;
        if (opc == OP_LDI) begin GRA = 1'b1; Rin = 1'b1; end
        else               MARin = 1'b1;
      end
      S_T6: begin
        if (opc == OP_LD) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (opc == OP_ST) begin
          GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (opc == OP_LD) begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end else if (opc == OP_ST) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldst_control_unit.sv
// Directed bench for ldst_control_unit: each step compares the full control
// word against a hand-built expected value.
module tb_ldst_control_unit;

  logic        Clock, Reset, Stop;
  logic [31:0] IR;
  logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC;
  logic Read, Write, Cout, GRA, GRB, GRC, Rin, Rout, BAout, Run;
  logic [4:0] operation;

  int n_checks = 0;
  int n_pass   = 0;

  ldst_control_unit dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Cout(Cout), .GRA(GRA),
    .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .operation(operation), .Run(Run)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Control word bit positions
  localparam logic [24:0] C_PCOUT   = 25'h1 << 24;
  localparam logic [24:0] C_ZLOWOUT = 25'h1 << 23;
  localparam logic [24:0] C_MDROUT  = 25'h1 << 22;
  localparam logic [24:0] C_MARIN   = 25'h1 << 21;
  localparam logic [24:0] C_ZIN     = 25'h1 << 20;
  localparam logic [24:0] C_PCIN    = 25'h1 << 19;
  localparam logic [24:0] C_MDRIN   = 25'h1 << 18;
  localparam logic [24:0] C_IRIN    = 25'h1 << 17;
  localparam logic [24:0] C_YIN     = 25'h1 << 16;
  localparam logic [24:0] C_INCPC   = 25'h1 << 15;
  localparam logic [24:0] C_READ    = 25'h1 << 14;
  localparam logic [24:0] C_WRITE   = 25'h1 << 13;
  localparam logic [24:0] C_COUT    = 25'h1 << 12;
  localparam logic [24:0] C_GRA     = 25'h1 << 11;
  localparam logic [24:0] C_GRB     = 25'h1 << 10;
  localparam logic [24:0] C_RIN     = 25'h1 << 8;
  localparam logic [24:0] C_ROUT    = 25'h1 << 7;
  localparam logic [24:0] C_BAOUT   = 25'h1 << 6;
  localparam logic [24:0] C_ADD     = 25'(5'b00011) << 1;
  localparam logic [24:0] C_RUN     = 25'h1;

  localparam logic [24:0] E_IDLE = 25'h0;
  localparam logic [24:0] E_T0   = C_PCOUT | C_MARIN | C_INCPC | C_PCIN | C_RUN;
  localparam logic [24:0] E_T1   = C_READ | C_MDRIN | C_RUN;
  localparam logic [24:0] E_T2   = C_MDROUT | C_IRIN | C_RUN;
  localparam logic [24:0] E_T3   = C_GRB | C_BAOUT | C_YIN | C_RUN;
  localparam logic [24:0] E_T4   = C_COUT | C_ZIN | C_ADD | C_RUN;
  localparam logic [24:0] E_LD5  = C_ZLOWOUT | C_MARIN | C_RUN;
  localparam logic [24:0] E_LD6  = C_READ | C_MDRIN | C_RUN;
  localparam logic [24:0] E_LD7  = C_MDROUT | C_GRA | C_RIN | C_RUN;
  localparam logic [24:0] E_LDI5 = C_ZLOWOUT | C_GRA | C_RIN | C_RUN;
  localparam logic [24:0] E_ST6  = C_GRA | C_ROUT | C_MDRIN | C_RUN;
  localparam logic [24:0] E_ST7  = C_WRITE | C_RUN;

  logic [24:0] obs;
  assign obs = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                IncPC, Read, Write, Cout, GRA, GRB, GRC, Rin, Rout, BAout,
                operation, Run};

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [24:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    Reset = 1'b1; Stop = 1'b0; IR = 32'h0;
    #2 chk("reset_async", E_IDLE);
    tick(); chk("reset_hold", E_IDLE);
    Reset = 1'b0;
    #2 chk("reset_cycle", E_IDLE);

    // ld R2, 0x95(R0)
    IR = 32'h01000095;
    tick(); chk("ld_t0", E_T0);
    tick(); chk("ld_t1", E_T1);
    tick(); chk("ld_t2", E_T2);
    tick(); chk("ld_t3", E_T3);
    tick(); chk("ld_t4", E_T4);
    tick(); chk("ld_t5", E_LD5);
    tick(); chk("ld_t6", E_LD6);
    tick(); chk("ld_t7", E_LD7);
    IR = 32'h08800095;
    tick(); chk("ld_end_t0", E_T0);

    // ldi; IR is changed to a halt after T3 and must be ignored
    tick(); chk("ldi_t1", E_T1);
    tick(); chk("ldi_t2", E_T2);
    tick(); chk("ldi_t3", E_T3);
    IR = 32'hD8000000;
    tick(); chk("ldi_t4", E_T4);
    tick(); chk("ldi_t5", E_LDI5);
    IR = 32'h10880087;
    tick(); chk("ldi_end_t0", E_T0);

    // st 0x87(R1), R1
    tick(); chk("st_t1", E_T1);
    tick(); chk("st_t2", E_T2);
    tick(); chk("st_t3", E_T3);
    tick(); chk("st_t4", E_T4);
    tick(); chk("st_t5", E_LD5);
    tick(); chk("st_t6", E_ST6);
    tick(); chk("st_t7", E_ST7);
    IR = 32'h98000000;
    tick(); chk("st_end_t0", E_T0);

    // unimplemented opcode 10011 behaves as NOP
    tick(); chk("nop_t1", E_T1);
    tick(); chk("nop_t2", E_T2);
    tick(); chk("nop_t3", E_T3);
    IR = 32'h01000095;
    tick(); chk("nop_end_t0", E_T0);

    // ld with Stop pulsed only during T4: ignored
    tick(); chk("stp4_t1", E_T1);
    tick(); chk("stp4_t2", E_T2);
    tick(); chk("stp4_t3", E_T3);
    tick(); chk("stp4_t4", E_T4);
    Stop = 1'b1;
    tick(); chk("stp4_t5", E_LD5);
    Stop = 1'b0;
    tick(); chk("stp4_t6", E_LD6);
    tick(); chk("stp4_t7", E_LD7);
    tick(); chk("stp4_end_t0", E_T0);

    // ld interrupted by Reset in T5
    tick(); chk("rst_t1", E_T1);
    tick(); chk("rst_t2", E_T2);
    tick(); chk("rst_t3", E_T3);
    tick(); chk("rst_t4", E_T4);
    tick(); chk("rst_t5", E_LD5);
    #2 Reset = 1'b1;
    #1 chk("rst_async_zero", E_IDLE);
    tick(); chk("rst_hold1", E_IDLE);
    tick(); chk("rst_hold2", E_IDLE);
    Reset = 1'b0;
    #2 chk("rst_release", E_IDLE);
    tick(); chk("rst_first_t0", E_T0);

    // ld with Stop raised in T2 and held: only honoured at T7
    tick(); chk("stph_t1", E_T1);
    Stop = 1'b1;
    tick(); chk("stph_t2", E_T2);
    tick(); chk("stph_t3", E_T3);
    tick(); chk("stph_t4", E_T4);
    tick(); chk("stph_t5", E_LD5);
    tick(); chk("stph_t6", E_LD6);
    tick(); chk("stph_t7", E_LD7);
    tick(); chk("stph_halt", E_IDLE);
    tick(); chk("stph_halt2", E_IDLE);
    Stop = 1'b0;

    // Reset out of HALT, then execute a halt instruction
    Reset = 1'b1;
    tick(); Reset = 1'b0;
    IR = 32'hD8000000;
    tick(); chk("halt_t0", E_T0);
    tick(); chk("halt_t1", E_T1);
    tick(); chk("halt_t2", E_T2);
    tick(); chk("halt_t3", E_T3);
    for (int i = 0; i < 12; i++) begin
      tick(); chk($sformatf("halt_stay%0d", i), E_IDLE);
    end

    Reset = 1'b1;
    tick(); Reset = 1'b0;
    tick(); chk("post_halt_t0", E_T0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
